// File: rtl/crc_frame_packer_pkg.sv
// crc_frame_pkg: widths and FSM encoding shared by the CRC frame packer.
// Trailer word: CRC in [9:0], optional word count in [31:16].
package crc_frame_pkg;

   localparam int DATA_W    = 32;
   localparam int CRC_W     = 10;
   localparam int CNT_W     = 16;
   localparam int PAD_W     = DATA_W - CRC_W;
   localparam int LEN_PAD_W = DATA_W - CNT_W - CRC_W;
   localparam int LAT_W     = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_DATA    = 3'd2,
      S_WAIT    = 3'd3,
      S_TRAILER = 3'd4
   } state_e;

endpackage

// File: rtl/crc_frame_packer_if.sv
// crc_frame_packer_if: source stream, CRC engine and downstream signals.
// master = packer view, slave = source/engine/sink view.
interface crc_frame_packer_if;
   import crc_frame_pkg::*;

   logic [DATA_W-1:0] In_Data;
   logic              In_Valid;
   logic              In_Last;
   logic              In_Ready;
   logic [DATA_W-1:0] CRC_Data_In;
   logic              CRC_En;
   logic              CRC_Clr;
   logic [CRC_W-1:0]  CRC_Out;
   logic [DATA_W-1:0] Out_Data;
   logic              Out_Valid;
   logic              Out_Last;
   logic              Out_Ready;
   logic              Frame_Err;

   modport master (
      input  In_Data, In_Valid, In_Last, CRC_Out, Out_Ready,
      output In_Ready, CRC_Data_In, CRC_En, CRC_Clr,
      output Out_Data, Out_Valid, Out_Last, Frame_Err
   );

   modport slave (
      output In_Data, In_Valid, In_Last, CRC_Out, Out_Ready,
      input  In_Ready, CRC_Data_In, CRC_En, CRC_Clr,
      input  Out_Data, Out_Valid, Out_Last, Frame_Err
   );

endinterface

// File: rtl/crc_frame_packer_lat_timer.sv
// crc_lat_timer: loadable down-counter covering the CRC engine latency.
// Ports: clk, rst, load_i/val_i (preset), en_i (count), done_o (at zero).
module crc_lat_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         en_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (en_i && cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/crc_frame_packer.sv
// crc_frame_packer: clears the CRC engine per frame, feeds and forwards
// each word, then appends a CRC trailer word. Option: CRC_PACK_LEN_EN.
// Ports: Clock, Reset (sync, high); bus = source in, engine, sink out.
module crc_frame_packer
   import crc_frame_pkg::*;
#(
   parameter int CRC_LAT   = 1,
   parameter int MAX_WORDS = 256
) (
   input logic                Clock,
   input logic                Reset,
   crc_frame_packer_if.master bus
);

   localparam logic [LAT_W-1:0] LAT_M1  = LAT_W'(CRC_LAT - 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_e            state_q;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] crc_data_q;
   logic [DATA_W-1:0] trailer_d;
   logic              out_valid_q;
   logic              out_last_q;
   logic              crc_en_q;
   logic              crc_clr_q;
   logic              frame_err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              in_ready;
   logic              accept;
   logic              pop;
   logic              forced;
   logic              last_word;
   logic              tmr_done;

   assign pop       = out_valid_q & bus.Out_Ready;
   assign in_ready  = (state_q == S_DATA)
                    & (~out_valid_q | bus.Out_Ready);
   assign accept    = in_ready & bus.In_Valid;
   assign cnt_d     = cnt_q + CNT_W'(1);
   // Hitting the word limit without a delimiter closes the frame.
   assign forced    = (cnt_d == MAX_CNT) & ~bus.In_Last;
   assign last_word = bus.In_Last | forced;

   always_comb begin
`ifdef CRC_PACK_LEN_EN
      trailer_d = {cnt_q, {LEN_PAD_W{1'b0}}, bus.CRC_Out};
`else
      trailer_d = {{PAD_W{1'b0}}, bus.CRC_Out};
`endif
   end

   // Preset to CRC_LAT-1 so TRAILER is entered exactly when
   // CRC_Out first holds the final frame CRC.
   crc_lat_timer #(.W(LAT_W)) u_timer (
      .clk    (Clock),
      .rst    (Reset),
      .load_i (accept & last_word),
      .val_i  (LAT_M1),
      .en_i   (state_q == S_WAIT),
      .done_o (tmr_done)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         crc_data_q  <= '0;
         crc_en_q    <= 1'b0;
         crc_clr_q   <= 1'b0;
         frame_err_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         crc_en_q    <= 1'b0;
         crc_clr_q   <= 1'b0;
         frame_err_q <= 1'b0;
         if (pop) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         unique case (state_q)
            S_IDLE: begin
               if (bus.In_Valid && !out_valid_q) begin
                  state_q   <= S_CLEAR;
                  crc_clr_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (accept) begin
                  out_data_q  <= bus.In_Data;
                  crc_data_q  <= bus.In_Data;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
                  crc_en_q    <= 1'b1;
                  cnt_q       <= cnt_d;
                  if (last_word) begin
                     state_q     <= S_WAIT;
                     frame_err_q <= forced;
                  end
               end
            end
            S_WAIT: begin
               if (tmr_done) begin
                  state_q <= S_TRAILER;
               end
            end
            S_TRAILER: begin
               if (out_valid_q && out_last_q) begin
                  if (bus.Out_Ready) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                  end
               end else if (!out_valid_q || bus.Out_Ready) begin
                  out_data_q  <= trailer_d;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.In_Ready    = in_ready;
   assign bus.Out_Data    = out_data_q;
   assign bus.Out_Valid   = out_valid_q;
   assign bus.Out_Last    = out_last_q;
   assign bus.CRC_Data_In = crc_data_q;
   assign bus.CRC_En      = crc_en_q;
   assign bus.CRC_Clr     = crc_clr_q;
   assign bus.Frame_Err   = frame_err_q;

endmodule

// File: tb/tb_crc_frame_packer.sv
// tb_crc_frame_packer: directed frames through the packer with a CRC-10
// engine model and a scoreboard of expected output and engine words.
module tb_crc_frame_packer;

   localparam int CRC_LAT   = 2;
   localparam int MAX_WORDS = 4;
`ifdef CRC_PACK_LEN_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   crc_frame_packer_if bus();

   crc_frame_packer #(
      .CRC_LAT   (CRC_LAT),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int clr_cnt = 0;
   int ferr_cnt = 0;
   int en_cnt = 0;
   int data_cyc = 0;
   int tr_cyc = 0;
   logic [31:0] last_trailer = '0;

   logic [32:0] exp_q[$];
   logic [31:0] en_q[$];
   logic [31:0] fr_q[$];

   // CRC-10, poly x^10+x^9+x^5+x^4+x+1, MSB first.
   function automatic logic [9:0] crc_step(input logic [9:0] c,
                                           input logic [31:0] w);
      logic [9:0] r;
      logic fb;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         fb = r[9] ^ w[i];
         r = {r[8:0], 1'b0};
         if (fb) r = r ^ 10'h233;
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_trailer(input int n,
                                               input logic [9:0] c);
      logic [15:0] n16;
      n16 = 16'(n);
      return LEN_EN ? {n16, 6'b0, c} : {22'b0, c};
   endfunction

   // Engine model: clear/update on the edge, CRC_LAT-cycle visibility.
   logic [9:0] eng_q = '0;
   logic [9:0] eng_d1 = '0;
   always @(posedge clk) begin
      if (bus.CRC_Clr) eng_q <= '0;
      else if (bus.CRC_En) eng_q <= crc_step(eng_q, bus.CRC_Data_In);
      eng_d1 <= eng_q;
   end
   assign bus.CRC_Out = (CRC_LAT == 1) ? eng_q : eng_d1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: outputs sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.Out_Valid && bus.Out_Ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               chk("out_word", 64'({bus.Out_Last, bus.Out_Data}),
                   64'(exp_q.pop_front()));
               if (bus.Out_Last) begin
                  last_trailer = bus.Out_Data;
                  tr_cyc = cyc;
               end else begin
                  data_cyc = cyc;
               end
            end
         end
         if (bus.CRC_En) begin
            en_cnt++;
            chk("en_expected", 64'(en_q.size() != 0), 64'd1);
            if (en_q.size() != 0)
               chk("en_word", 64'(bus.CRC_Data_In), 64'(en_q.pop_front()));
         end
         if (bus.CRC_Clr) begin
            clr_cnt++;
            chk("clr_no_en", 64'(bus.CRC_En), 64'd0);
         end
         if (bus.Frame_Err) ferr_cnt++;
      end
   end

   task automatic expect_frame(input logic with_trailer);
      logic [9:0] c;
      c = '0;
      foreach (fr_q[i]) begin
         exp_q.push_back({1'b0, fr_q[i]});
         en_q.push_back(fr_q[i]);
         c = crc_step(c, fr_q[i]);
      end
      if (with_trailer)
         exp_q.push_back({1'b1, exp_trailer(fr_q.size(), c)});
      fr_q.delete();
   endtask

   task automatic send_word(input logic [31:0] d, input logic l,
                            output int waits);
      int t;
      logic got;
      waits = 0;
      got = 1'b0;
      t = 0;
      bus.In_Data = d;
      bus.In_Last = l;
      bus.In_Valid = 1'b1;
      while (!got && t < 200) begin
         @(negedge clk);
         if (bus.In_Ready) got = 1'b1;
         else waits++;
         t++;
      end
      chk("accept_timeout", 64'(got), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.In_Valid = 1'b0;
      bus.In_Last = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain_timeout", 64'(t < 300), 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int wsum;
      int c0;
      int f0;
      logic [31:0] held;

      bus.In_Data = '0;
      bus.In_Valid = 1'b0;
      bus.In_Last = 1'b0;
      bus.Out_Ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.Out_Valid), 64'd0);
      chk("rst_out_data", 64'(bus.Out_Data), 64'd0);
      chk("rst_out_last", 64'(bus.Out_Last), 64'd0);
      chk("rst_crc_data", 64'(bus.CRC_Data_In), 64'd0);
      chk("rst_ctrl", 64'({bus.CRC_En, bus.CRC_Clr, bus.Frame_Err}),
          64'd0);
      chk("rst_in_ready", 64'(bus.In_Ready), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: single-word frame
      fr_q.push_back(32'hC11F_C1F5);
      expect_frame(1'b1);
      send_word(32'hC11F_C1F5, 1'b1, w);
      idle_in();
      drain();
      chk("t1_clr_cnt", 64'(clr_cnt), 64'd1);
      chk("t1_en_cnt", 64'(en_cnt), 64'd1);

      // 2: back-to-back 4-word frame
      for (int i = 0; i < 4; i++) fr_q.push_back(32'h1000_0001 * (i + 3));
      expect_frame(1'b1);
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         send_word(32'h1000_0001 * (i + 3), 1'(i == 3), w);
         if (i > 0) wsum += w;
      end
      idle_in();
      drain();
      chk("t2_no_gaps", 64'(wsum), 64'd0);
      chk("t2_trailer_lat", 64'(tr_cyc - data_cyc), 64'(CRC_LAT + 1));

      // 3: downstream stall mid-frame
      fr_q.push_back(32'hDEAD_0001);
      fr_q.push_back(32'hBEEF_0002);
      fr_q.push_back(32'hCAFE_0003);
      fr_q.push_back(32'hF00D_0004);
      expect_frame(1'b1);
      send_word(32'hDEAD_0001, 1'b0, w);
      send_word(32'hBEEF_0002, 1'b0, w);
      held = 32'hBEEF_0002;
      bus.Out_Ready = 1'b0;
      bus.In_Data = 32'hCAFE_0003;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 64'(bus.Out_Valid), 64'd1);
         chk("t3_hold_data", 64'(bus.Out_Data), 64'(held));
         chk("t3_in_ready", 64'(bus.In_Ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.Out_Ready = 1'b1;
      send_word(32'hCAFE_0003, 1'b0, w);
      send_word(32'hF00D_0004, 1'b1, w);
      idle_in();
      drain();

      // 4: forced termination at MAX_WORDS
      c0 = clr_cnt;
      f0 = ferr_cnt;
      for (int i = 0; i < 4; i++) fr_q.push_back(32'hA5A5_0010 + i);
      expect_frame(1'b1);
      for (int i = 4; i < 7; i++) fr_q.push_back(32'hA5A5_0010 + i);
      expect_frame(1'b1);
      for (int i = 0; i < 7; i++)
         send_word(32'hA5A5_0010 + i, 1'(i == 6), w);
      idle_in();
      drain();
      chk("t4_ferr_once", 64'(ferr_cnt - f0), 64'd1);
      chk("t4_two_clears", 64'(clr_cnt - c0), 64'd2);

      // 5: reset in DATA after two words
      fr_q.push_back(32'h0BAD_0001);
      fr_q.push_back(32'h0BAD_0002);
      expect_frame(1'b0);
      send_word(32'h0BAD_0001, 1'b0, w);
      send_word(32'h0BAD_0002, 1'b0, w);
      idle_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      en_q.delete();
      chk("t5_out_valid", 64'(bus.Out_Valid), 64'd0);
      chk("t5_out_data", 64'(bus.Out_Data), 64'd0);
      chk("t5_crc_data", 64'(bus.CRC_Data_In), 64'd0);
      chk("t5_ctrl", 64'({bus.CRC_En, bus.CRC_Clr, bus.Frame_Err,
                          bus.Out_Last}), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("t5_quiet", 64'(bus.Out_Valid), 64'd0);
      fr_q.push_back(32'h7777_1234);
      fr_q.push_back(32'h0000_FFFF);
      expect_frame(1'b1);
      send_word(32'h7777_1234, 1'b0, w);
      send_word(32'h0000_FFFF, 1'b1, w);
      idle_in();
      drain();

      // 6: trailer layout, 3-word frame
      for (int i = 0; i < 3; i++) fr_q.push_back(32'h3C3C_0100 + i);
      expect_frame(1'b1);
      for (int i = 0; i < 3; i++)
         send_word(32'h3C3C_0100 + i, 1'(i == 2), w);
      idle_in();
      drain();
`ifdef CRC_PACK_LEN_EN
      chk("t6_len", 64'(last_trailer[31:16]), 64'd3);
      chk("t6_pad", 64'(last_trailer[15:10]), 64'd0);
`else
      chk("t6_upper", 64'(last_trailer[31:10]), 64'd0);
`endif

      chk("end_out_q", 64'(exp_q.size()), 64'd0);
      chk("end_en_q", 64'(en_q.size()), 64'd0);
      chk("end_clr_cnt", 64'(clr_cnt), 64'd8);
      chk("end_ferr_cnt", 64'(ferr_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule
